// File: rtl/culsans_exit_monitor.sv
// culsans_exit_monitor: passive HTIF tohost snooper on the memory-side AXI
// write channels. Captures the first W beat of each tracked write. On commit
// it either latches the sticky exit word or pulses a syscall notification.
// Optional feature macro: CULSANS_EXIT_WATCHDOG_EN (cycle watchdog forcing exit).
module culsans_exit_monitor #(
  parameter int unsigned AddrWidth     = 64,
  parameter logic [63:0] TohostAddr    = 64'h8000_1000,
  parameter logic [31:0] TimeoutCycles = 32'd50_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst,
  input  logic                 aw_valid_i,
  input  logic                 aw_ready_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 w_valid_i,
  input  logic                 w_ready_i,
  input  logic                 w_last_i,
  input  logic [63:0]          w_data_i,
  input  logic [7:0]           w_strb_i,
  input  logic                 b_valid_i,
  input  logic                 b_ready_i,
  output logic [31:0]          exit_o,
  output logic                 syscall_o,
  output logic [63:0]          syscall_data_o,
  output logic                 overlap_o,
  output logic                 timeout_o
);

  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = 8;
  localparam int unsigned ExitWidth = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HAVE_ADDR = 3'd1,
    HAVE_DATA = 3'd2,
    DRAIN_W   = 3'd3,
    WAIT_B    = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic                   addr_vld_q, addr_vld_d;
  logic                   match_q, match_d;
  logic [DataWidth-1:0]   data_q, data_d;
  logic                   nxt_vld_q, nxt_vld_d;
  logic                   nxt_last_q, nxt_last_d;
  logic [DataWidth-1:0]   nxt_data_q, nxt_data_d;
  logic                   commit_q, commit_d;
  logic                   commit_match_q, commit_match_d;
  logic [DataWidth-1:0]   commit_data_q, commit_data_d;
  logic [ExitWidth-1:0]   exit_q, exit_d;
  logic                   syscall_q, syscall_d;
  logic [DataWidth-1:0]   syscall_data_q, syscall_data_d;
  logic                   overlap_q, overlap_d;

  logic                   aw_hs, w_hs, b_hs;
  logic                   addr_match;
  logic [DataWidth-1:0]   w_data_masked;
  logic                   exit_commit;
  logic [2:0]             unused_addr_lsb;

  assign aw_hs      = aw_valid_i & aw_ready_i;
  assign w_hs       = w_valid_i & w_ready_i;
  assign b_hs       = b_valid_i & b_ready_i;
  assign addr_match = (aw_addr_i[AddrWidth-1:3] == TohostAddr[AddrWidth-1:3]);
  assign unused_addr_lsb = aw_addr_i[2:0];

  // Zero the bytes whose strobe is low
  always_comb begin
    w_data_masked = '0;
    for (int i = 0; i < int'(StrbWidth); i++) begin
      w_data_masked[i*8 +: 8] = w_strb_i[i] ? w_data_i[i*8 +: 8] : 8'h00;
    end
  end

  // Transaction tracker: next state, address/data capture and commit request
  always_comb begin
    state_d        = state_q;
    addr_vld_d     = addr_vld_q;
    match_d        = match_q;
    data_d         = data_q;
    nxt_vld_d      = nxt_vld_q;
    nxt_last_d     = nxt_last_q;
    nxt_data_d     = nxt_data_q;
    commit_d       = 1'b0;
    commit_match_d = commit_match_q;
    commit_data_d  = commit_data_q;
    overlap_d      = overlap_q;

    unique case (state_q)
      IDLE: begin
        if (aw_hs && w_hs) begin
          addr_vld_d = 1'b1;
          match_d    = addr_match;
          data_d     = w_data_masked;
          state_d    = w_last_i ? WAIT_B : DRAIN_W;
        end else if (aw_hs) begin
          addr_vld_d = 1'b1;
          match_d    = addr_match;
          state_d    = HAVE_ADDR;
        end else if (w_hs) begin
          addr_vld_d = 1'b0;
          data_d     = w_data_masked;
          state_d    = w_last_i ? HAVE_DATA : DRAIN_W;
        end
      end
      HAVE_ADDR: begin
        if (aw_hs) overlap_d = 1'b1;
        if (w_hs) begin
          data_d  = w_data_masked;
          state_d = w_last_i ? WAIT_B : DRAIN_W;
        end
      end
      HAVE_DATA: begin
        if (aw_hs) begin
          addr_vld_d = 1'b1;
          match_d    = addr_match;
          state_d    = WAIT_B;
        end
      end
      DRAIN_W: begin
        if (aw_hs) overlap_d = 1'b1;
        if (w_hs && w_last_i) begin
          state_d = addr_vld_q ? WAIT_B : HAVE_DATA;
        end
      end
      WAIT_B: begin
        if (aw_hs) overlap_d = 1'b1;
        // W beats here belong to the next transaction; keep its first beat
        if (w_hs) begin
          if (!nxt_vld_q) begin
            nxt_vld_d  = 1'b1;
            nxt_data_d = w_data_masked;
            nxt_last_d = w_last_i;
          end else if (!nxt_last_q && w_last_i) begin
            nxt_last_d = 1'b1;
          end
        end
        if (b_hs) begin
          commit_d       = 1'b1;
          commit_match_d = match_q;
          commit_data_d  = data_q;
          addr_vld_d     = 1'b0;
          if (nxt_vld_d) begin
            data_d    = nxt_data_d;
            nxt_vld_d = 1'b0;
            state_d   = nxt_last_d ? HAVE_DATA : DRAIN_W;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef CULSANS_EXIT_WATCHDOG_EN
  localparam logic [31:0] TimeoutLast = TimeoutCycles - 32'd1;

  logic [31:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TimeoutCycles;
`endif

  assign exit_commit = commit_q && commit_match_q && (commit_data_q != '0)
                       && commit_data_q[0] && !exit_q[0];

  // Commit outputs: first exit wins, non-exit writes raise a syscall pulse
  always_comb begin
    exit_d         = exit_q;
    syscall_d      = 1'b0;
    syscall_data_d = syscall_data_q;
`ifdef CULSANS_EXIT_WATCHDOG_EN
    cnt_d          = cnt_q;
    timeout_d      = timeout_q;
`endif

    if (exit_commit) begin
      exit_d = commit_data_q[ExitWidth-1:0];
    end
    if (commit_q && commit_match_q && (commit_data_q != '0) && !commit_data_q[0]) begin
      syscall_d      = 1'b1;
      syscall_data_d = commit_data_q;
    end

`ifdef CULSANS_EXIT_WATCHDOG_EN
    // Watchdog runs until an exit is latched; a same-cycle exit commit wins
    if (!exit_q[0]) begin
      if (cnt_q == TimeoutLast) begin
        if (!exit_commit) begin
          exit_d    = 32'hFFFF_FFFF;
          timeout_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      addr_vld_q     <= 1'b0;
      match_q        <= 1'b0;
      data_q         <= '0;
      nxt_vld_q      <= 1'b0;
      nxt_last_q     <= 1'b0;
      nxt_data_q     <= '0;
      commit_q       <= 1'b0;
      commit_match_q <= 1'b0;
      commit_data_q  <= '0;
      exit_q         <= '0;
      syscall_q      <= 1'b0;
      syscall_data_q <= '0;
      overlap_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_vld_q     <= addr_vld_d;
      match_q        <= match_d;
      data_q         <= data_d;
      nxt_vld_q      <= nxt_vld_d;
      nxt_last_q     <= nxt_last_d;
      nxt_data_q     <= nxt_data_d;
      commit_q       <= commit_d;
      commit_match_q <= commit_match_d;
      commit_data_q  <= commit_data_d;
      exit_q         <= exit_d;
      syscall_q      <= syscall_d;
      syscall_data_q <= syscall_data_d;
      overlap_q      <= overlap_d;
    end
  end

`ifdef CULSANS_EXIT_WATCHDOG_EN
  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign exit_o         = exit_q;
  assign syscall_o      = syscall_q;
  assign syscall_data_o = syscall_data_q;
  assign overlap_o      = overlap_q;

endmodule

// File: tb/tb_culsans_exit_monitor.sv
// Bench for culsans_exit_monitor: table of single write transactions checked
// through an expected-value queue, plus hand sequences for overlap, reset in
// WAIT_B and a W beat arriving together with B.
module tb_culsans_exit_monitor;

  logic        clk_i;
  logic        rst;
  logic        aw_valid_i, aw_ready_i;
  logic [63:0] aw_addr_i;
  logic        w_valid_i, w_ready_i, w_last_i;
  logic [63:0] w_data_i;
  logic [7:0]  w_strb_i;
  logic        b_valid_i, b_ready_i;
  logic [31:0] exit_o;
  logic        syscall_o;
  logic [63:0] syscall_data_o;
  logic        overlap_o;
  logic        timeout_o;

  culsans_exit_monitor #(
    .AddrWidth     (64),
    .TohostAddr    (64'h8000_1000),
    .TimeoutCycles (32'd100)
  ) dut (
    .clk_i          (clk_i),
    .rst            (rst),
    .aw_valid_i     (aw_valid_i),
    .aw_ready_i     (aw_ready_i),
    .aw_addr_i      (aw_addr_i),
    .w_valid_i      (w_valid_i),
    .w_ready_i      (w_ready_i),
    .w_last_i       (w_last_i),
    .w_data_i       (w_data_i),
    .w_strb_i       (w_strb_i),
    .b_valid_i      (b_valid_i),
    .b_ready_i      (b_ready_i),
    .exit_o         (exit_o),
    .syscall_o      (syscall_o),
    .syscall_data_o (syscall_data_o),
    .overlap_o      (overlap_o),
    .timeout_o      (timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  localparam logic [63:0] TOHOST = 64'h8000_1000;

  // mode: 0 = AW before W, 1 = W before AW, 2 = AW and first W together
  typedef struct {
    bit          rst_before;
    int          mode;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    int          beats;
    logic [31:0] exp_exit;
    bit          exp_sys;
    logic [63:0] exp_sdata;
  } vec_t;

  typedef struct {
    logic [31:0] exit_v;
    bit          sys;
    logic [63:0] sdata;
  } exp_t;

  vec_t vecs [10];
  exp_t sb_q [$];
  int   total = 0;
  int   bad   = 0;
  logic [31:0] last_exit;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    aw_valid_i = 1'b0; aw_ready_i = 1'b0; aw_addr_i = '0;
    w_valid_i  = 1'b0; w_ready_i  = 1'b0; w_last_i  = 1'b0;
    w_data_i   = '0;   w_strb_i   = '0;
    b_valid_i  = 1'b0; b_ready_i  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst = 1'b0;
    repeat (2) @(negedge clk_i);
    rst = 1'b1;
  endtask

  task automatic aw_on(input logic [63:0] a);
    aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_addr_i = a;
  endtask

  task automatic w_on(input logic [63:0] d, input logic [7:0] s, input logic last);
    w_valid_i = 1'b1; w_ready_i = 1'b1; w_data_i = d; w_strb_i = s; w_last_i = last;
  endtask

  task automatic send_beats(input vec_t v, input bit drop_aw);
    for (int b = 0; b < v.beats; b++) begin
      if (b == 0) w_on(v.data, v.strb, 1'(v.beats == 1));
      else        w_on(64'h1, 8'hFF, 1'(b == v.beats - 1));
      @(negedge clk_i);
      if (drop_aw) aw_valid_i = 1'b0;
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
  endtask

  // Drive one full write transaction ending with the B handshake
  task automatic do_txn(input vec_t v);
    @(negedge clk_i);
    case (v.mode)
      0: begin
        aw_on(v.addr);
        @(negedge clk_i);
        aw_valid_i = 1'b0;
        send_beats(v, 1'b0);
      end
      1: begin
        send_beats(v, 1'b0);
        aw_on(v.addr);
        @(negedge clk_i);
        aw_valid_i = 1'b0;
      end
      default: begin
        aw_on(v.addr);
        send_beats(v, 1'b1);
      end
    endcase
    b_valid_i = 1'b1; b_ready_i = 1'b1;
    @(negedge clk_i);
    b_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 0, TOHOST,                64'h1,                  8'hFF, 1, 32'h1, 1'b0, 64'h0};
    vecs[1] = '{1'b1, 1, TOHOST,                64'h2A,                 8'hFF, 1, 32'h0, 1'b1, 64'h2A};
    vecs[2] = '{1'b0, 2, 64'h8000_1008,         64'h1,                  8'hFF, 1, 32'h0, 1'b0, 64'h2A};
    vecs[3] = '{1'b0, 0, 64'h8000_1004,         64'h0000_1234_0000_0010, 8'h0F, 1, 32'h0, 1'b1, 64'h10};
    vecs[4] = '{1'b0, 0, TOHOST,                64'h0,                  8'hFF, 1, 32'h0, 1'b0, 64'h10};
    vecs[5] = '{1'b0, 1, TOHOST,                64'hFF,                 8'h00, 1, 32'h0, 1'b0, 64'h10};
    vecs[6] = '{1'b0, 0, 64'h9000_1000,         64'h1,                  8'hFF, 1, 32'h0, 1'b0, 64'h10};
    vecs[7] = '{1'b0, 0, TOHOST,                64'h7,                  8'hFF, 4, 32'h7, 1'b0, 64'h10};
    vecs[8] = '{1'b0, 1, TOHOST,                64'h3,                  8'hFF, 1, 32'h7, 1'b0, 64'h10};
    vecs[9] = '{1'b0, 2, TOHOST,                64'h44,                 8'hFF, 1, 32'h7, 1'b1, 64'h44};

    idle_bus();
    rst = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_exit",    64'(exit_o),    64'h0);
    chk("rst_syscall", 64'(syscall_o), 64'h0);
    chk("rst_sdata",   syscall_data_o, 64'h0);
    chk("rst_overlap", 64'(overlap_o), 64'h0);
    chk("rst_timeout", 64'(timeout_o), 64'h0);
    rst = 1'b1;

`ifdef CULSANS_EXIT_WATCHDOG_EN
    // Watchdog: exit forced on the 100th edge after reset release
    do_reset();
    repeat (99) @(negedge clk_i);
    chk("wd_exit_early",    64'(exit_o),    64'h0);
    chk("wd_timeout_early", 64'(timeout_o), 64'h0);
    @(negedge clk_i);
    chk("wd_exit",    64'(exit_o),    64'hFFFF_FFFF);
    chk("wd_timeout", 64'(timeout_o), 64'h1);
`else
    last_exit = 32'h0;
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      if (vecs[i].rst_before) begin
        do_reset();
        last_exit = 32'h0;
      end
      e.exit_v = vecs[i].exp_exit;
      e.sys    = vecs[i].exp_sys;
      e.sdata  = vecs[i].exp_sdata;
      sb_q.push_back(e);
      do_txn(vecs[i]);
      // One cycle after the B edge nothing has changed yet
      chk($sformatf("v%0d_lat_sys", i),  64'(syscall_o), 64'h0);
      chk($sformatf("v%0d_lat_exit", i), 64'(exit_o),    64'(last_exit));
      @(negedge clk_i);
      if (sb_q.size() == 0) begin
        chk($sformatf("v%0d_sb_empty", i), 64'h1, 64'h0);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d_exit", i),    64'(exit_o),    64'(e.exit_v));
        chk($sformatf("v%0d_syscall", i), 64'(syscall_o), 64'(e.sys));
        chk($sformatf("v%0d_sdata", i),   syscall_data_o, e.sdata);
        last_exit = e.exit_v;
      end
      @(negedge clk_i);
      chk($sformatf("v%0d_pulse_end", i), 64'(syscall_o), 64'h0);
    end

    // Second AW while waiting for B, then reset with a write outstanding
    do_reset();
    @(negedge clk_i);
    aw_on(TOHOST);
    @(negedge clk_i);
    aw_valid_i = 1'b0;
    w_on(64'h5, 8'hFF, 1'b1);
    @(negedge clk_i);
    w_valid_i = 1'b0;
    aw_on(TOHOST);
    @(negedge clk_i);
    aw_valid_i = 1'b0;
    chk("ovl_flag", 64'(overlap_o), 64'h1);
    b_valid_i = 1'b1; b_ready_i = 1'b1;
    @(negedge clk_i);
    b_valid_i = 1'b0;
    @(negedge clk_i);
    chk("ovl_exit",   64'(exit_o),    64'h5);
    chk("ovl_sticky", 64'(overlap_o), 64'h1);

    aw_on(TOHOST);
    @(negedge clk_i);
    aw_valid_i = 1'b0;
    w_on(64'h66, 8'hFF, 1'b1);
    @(negedge clk_i);
    w_valid_i = 1'b0;
    rst = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_exit",    64'(exit_o),    64'h0);
    chk("mid_rst_overlap", 64'(overlap_o), 64'h0);
    chk("mid_rst_syscall", 64'(syscall_o), 64'h0);
    chk("mid_rst_sdata",   syscall_data_o, 64'h0);
    rst = 1'b1;
    @(negedge clk_i);
    b_valid_i = 1'b1; b_ready_i = 1'b1;
    @(negedge clk_i);
    b_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("post_rst_sdata", syscall_data_o, 64'h0);
    chk("post_rst_exit",  64'(exit_o),    64'h0);

    // Next transaction's W beat lands in the same cycle as the B handshake
    do_reset();
    @(negedge clk_i);
    aw_on(TOHOST);
    @(negedge clk_i);
    aw_valid_i = 1'b0;
    w_on(64'h10, 8'hFF, 1'b1);
    @(negedge clk_i);
    w_on(64'h20, 8'hFF, 1'b1);
    b_valid_i = 1'b1; b_ready_i = 1'b1;
    @(negedge clk_i);
    w_valid_i = 1'b0; b_valid_i = 1'b0;
    @(negedge clk_i);
    chk("buf_first_sys",   64'(syscall_o), 64'h1);
    chk("buf_first_sdata", syscall_data_o, 64'h10);
    aw_on(TOHOST);
    @(negedge clk_i);
    aw_valid_i = 1'b0;
    b_valid_i = 1'b1; b_ready_i = 1'b1;
    @(negedge clk_i);
    b_valid_i = 1'b0;
    @(negedge clk_i);
    chk("buf_second_sys",   64'(syscall_o), 64'h1);
    chk("buf_second_sdata", syscall_data_o, 64'h20);
    chk("buf_overlap",      64'(overlap_o), 64'h0);
    chk("no_watchdog",      64'(timeout_o), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/culsans_exit_monitor.md
# culsans_exit_monitor

Passive HTIF `tohost` snooper between the Culsans SoC memory-side AXI write channels and the top-level `exit_o` port. It watches AW/W/B handshakes and captures writes that hit the `tohost` doubleword. On each committed write it either latches the sticky 32-bit exit word consumed by the simulation end-of-run logic, or pulses a syscall notification. It never drives `ready`/`valid` signals and never alters bus traffic.

## Interface
- `AddrWidth`, 64, AXI address width
- `TohostAddr`, 64'h8000_1000, byte address of `tohost`; compared on bits [AddrWidth-1:3]
- `TimeoutCycles`, 32'd50_000_000, watchdog limit; used only with `CULSANS_EXIT_WATCHDOG_EN`
- `clk_i`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-low
- `aw_valid_i`, `aw_ready_i`  in  1  AW handshake snoop
- `aw_addr_i`  in  AddrWidth  AW address
- `w_valid_i`, `w_ready_i`, `w_last_i`  in  1  W handshake snoop
- `w_data_i`  in  64  write data
- `w_strb_i`  in  8  byte strobes
- `b_valid_i`, `b_ready_i`  in  1  B handshake snoop
- `exit_o`  out  32  sticky exit word; bit 0 = finished, [31:1] = exit code
- `syscall_o`  out  1  one-cycle pulse on a committed non-exit `tohost` write
- `syscall_data_o`  out  64  payload of last syscall write, held
- `overlap_o`  out  1  sticky: new AW accepted while a transaction is tracked
- `timeout_o`  out  1  sticky: watchdog fired

## Operation
- Handshake = `valid & ready` on the same rising edge. Transactions are tracked one at a time.
- FSM states: IDLE, HAVE_ADDR, HAVE_DATA, DRAIN_W, WAIT_B.
  - IDLE: AW hs only -> HAVE_ADDR. First-beat W hs only -> HAVE_DATA, or DRAIN_W if `!w_last_i`. Both in the same cycle -> WAIT_B if `w_last_i`, else DRAIN_W.
  - HAVE_ADDR: first W hs -> WAIT_B if last, else DRAIN_W.
  - HAVE_DATA: AW hs -> WAIT_B.
  - DRAIN_W: W beats are ignored for data. The state exits on the `w_last_i` beat, going to WAIT_B if the address is held, else to HAVE_DATA.
  - WAIT_B: B hs commits the transaction and returns to IDLE.
- Only the first W beat is captured. Bytes with strobe 0 are captured as 0x00.
- Address match: `aw_addr_i[AddrWidth-1:3] == TohostAddr[AddrWidth-1:3]`, registered at AW hs.
- On commit with match and captured data != 0:
  - data[0]=1: `exit_o <= data[31:0]`, only if `exit_o[0]==0`. First exit wins; later writes are ignored.
  - data[0]=0: `syscall_o` pulses on the following cycle; `syscall_data_o <= data`.
- Commit with no match, or with data == 0: no output change.
- AW hs in any state other than IDLE or HAVE_DATA sets `overlap_o`. The extra AW is dropped; tracking continues.
- A W hs in WAIT_B is treated as the start of the next transaction's data and is buffered; a B hs in the same cycle still commits.
- Reset mid-transaction discards all tracked state.

## Timing
- Reset values: `exit_o`=0, `syscall_o`=0, `syscall_data_o`=0, `overlap_o`=0, `timeout_o`=0; FSM = IDLE.
- Commit latency: outputs update on the edge after the B-hs edge, i.e. they are visible 1 cycle after the B handshake.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `CULSANS_EXIT_WATCHDOG_EN` defined:
  - A 32-bit cycle counter runs from reset release while `exit_o[0]==0`.
  - When the counter equals `TimeoutCycles-1`, the next edge sets `exit_o <= 32'hFFFF_FFFF` and `timeout_o <= 1`, and the counter stops.
  - An exit commit in the same cycle wins: its value is latched and `timeout_o` stays 0.
- Macro undefined: no counter is instantiated, `timeout_o` is tied 0, and `TimeoutCycles` is unused.

## Test plan
- AW(0x8000_1000) then W(data=0x1, strb=0xFF, last) then B -> `exit_o`=0x0000_0001 one cycle after the B hs.
- W before AW, data=0x2A, then B -> `syscall_o` pulse of exactly 1 cycle, `syscall_data_o`=0x2A, `exit_o`=0.
- AW and W on the same cycle to 0x8000_1008, data=0x1 -> no change on any output.
- 4-beat burst to `tohost`, first beat 0x0000_0007, later beats 0x1 -> `exit_o`=0x7; a second exit write of 0x3 then leaves `exit_o`=0x7.
- Second AW hs while in WAIT_B -> `overlap_o`=1; the first transaction still commits correctly; reset asserted mid-WAIT_B -> all outputs return to 0 and the FSM is IDLE.
- With `CULSANS_EXIT_WATCHDOG_EN` and `TimeoutCycles`=100, no writes -> `exit_o`=0xFFFF_FFFF and `timeout_o`=1 at cycle 100 after reset release.
